// File: rtl/arb_req_pkg.sv
// Shared types and defaults for the arbiter requester agent.
// The optional request timeout is enabled with the REQ_TIMEOUT_EN macro (see arb_requester).
package arb_req_pkg;

    localparam int unsigned ARB_AW      = 16;
    localparam int unsigned ARB_LW      = 4;
    localparam int unsigned ARB_DEPTH   = 4;
    localparam int unsigned ARB_MIN_GAP = 1;
    localparam int unsigned ARB_TIMEOUT = 255;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StGap
    } state_e;

    // Command as seen at the default widths.
    typedef struct packed {
        logic [ARB_AW-1:0] addr;
        logic [ARB_LW-1:0] len;
    } cmd_t;

    // Index width for a counter/pointer spanning n entries, never narrower than 1 bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_req_fifo.sv
// Synchronous command FIFO: registered storage, extra-bit pointers for full/empty.
// Pop on empty and push on full are ignored.
module arb_req_fifo
    import arb_req_pkg::*;
#(
    parameter int unsigned W     = 20,
    parameter int unsigned DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int unsigned PW = idx_w(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [PW:0]  r_wr;
    logic [PW:0]  r_rd;
    logic         w_do_push;
    logic         w_do_pop;

    assign o_empty   = (r_wr == r_rd);
    assign o_full    = (r_wr[PW] != r_rd[PW]) && (r_wr[PW-1:0] == r_rd[PW-1:0]);
    assign o_data    = r_mem[r_rd[PW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Pointer update; simultaneous push and pop leaves occupancy unchanged.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr[PW-1:0]] <= i_data;
    end

endmodule

// File: rtl/arb_requester.sv
// Client-side agent for a fixed-priority shared-bus arbiter: queues commands, requests the
// bus, issues one address beat per granted cycle and backs off for MIN_GAP cycles per burst.
// Optional feature: define REQ_TIMEOUT_EN to abort bursts left ungranted for TIMEOUT cycles.
module arb_requester
    import arb_req_pkg::*;
#(
    parameter int unsigned AW      = ARB_AW,
    parameter int unsigned LW      = ARB_LW,
    parameter int unsigned DEPTH   = ARB_DEPTH,
    parameter int unsigned MIN_GAP = ARB_MIN_GAP,
    parameter int unsigned TIMEOUT = ARB_TIMEOUT
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic [AW-1:0] i_cmd_addr,
    input  logic [LW-1:0] i_cmd_len,
    output logic          o_req,
    input  logic          i_gnt,
    output logic          o_bus_valid,
    output logic [AW-1:0] o_bus_addr,
    output logic          o_bus_last,
    output logic          o_err_timeout
);

    localparam int unsigned CW       = AW + LW;
    localparam int unsigned GW       = idx_w(MIN_GAP);
    localparam int unsigned GAP_LAST = (MIN_GAP > 0) ? MIN_GAP - 1 : 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
    } cmd_s;

    state_e        r_state;
    state_e        w_state_d;
    logic [AW-1:0] r_addr;
    logic [LW-1:0] r_rem;
    logic [GW-1:0] r_gap;
    logic          r_bus_valid;
    logic [AW-1:0] r_bus_addr;
    logic          r_bus_last;

    cmd_s          w_push_cmd;
    cmd_s          w_head;
    logic [CW-1:0] w_head_bits;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_fire;
    logic          w_last;
    logic          w_abort;
    logic          w_gap_done;

    // ---------------------------------------------------------------------------------------
    // Command queue
    // ---------------------------------------------------------------------------------------
    assign o_cmd_ready = !w_full;
    assign w_push      = i_cmd_valid && o_cmd_ready;
    assign w_push_cmd  = '{addr: i_cmd_addr, len: i_cmd_len};
    assign w_head      = cmd_s'(w_head_bits);

    arb_req_fifo #(
        .W     (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  (w_push_cmd),
        .i_pop   (w_pop),
        .o_data  (w_head_bits),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // ---------------------------------------------------------------------------------------
    // Burst control
    // ---------------------------------------------------------------------------------------
    assign o_req      = (r_state == StBusy);
    assign w_fire     = (r_state == StBusy) && i_gnt;
    assign w_last     = w_fire && (r_rem == '0);
    assign w_gap_done = (r_gap == GW'(GAP_LAST));

    // Next-state decode; the final gap cycle doubles as the pop cycle so req stays low for
    // exactly MIN_GAP cycles between queued bursts.
    always_comb begin
        w_state_d = r_state;
        w_pop     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_state_d = StBusy;
                end
            end
            StBusy: begin
                if (w_last || w_abort) begin
                    w_state_d = (MIN_GAP == 0) ? StIdle : StGap;
                end
            end
            StGap: begin
                if (w_gap_done) begin
                    if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_state_d = StBusy;
                    end else begin
                        w_state_d = StIdle;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= StIdle;
        else       r_state <= w_state_d;
    end

    // Work registers: load on pop, advance on every granted beat, hold otherwise.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr <= '0;
            r_rem  <= '0;
        end else if (w_pop) begin
            r_addr <= w_head.addr;
            r_rem  <= w_head.len;
        end else if (w_fire) begin
            r_addr <= r_addr + 1'b1;
            r_rem  <= r_rem - 1'b1;
        end
    end

    // Gap counter runs only while in the gap state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_gap <= '0;
        end else if ((r_state == StGap) && !w_gap_done) begin
            r_gap <= r_gap + 1'b1;
        end else begin
            r_gap <= '0;
        end
    end

    // Beat output registers; address holds between beats, valid/last pulse per beat.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bus_valid <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_last  <= 1'b0;
        end else begin
            r_bus_valid <= w_fire;
            r_bus_last  <= w_last;
            if (w_fire) r_bus_addr <= r_addr;
        end
    end

    assign o_bus_valid = r_bus_valid;
    assign o_bus_addr  = r_bus_addr;
    assign o_bus_last  = r_bus_last;

    // ---------------------------------------------------------------------------------------
    // Request timeout
    // ---------------------------------------------------------------------------------------
`ifdef REQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_wait;
    logic          r_err;

    assign w_abort       = (r_state == StBusy) && !i_gnt && (r_wait == TW'(TIMEOUT - 1));
    assign o_err_timeout = r_err;

    // Count consecutive ungranted busy cycles; any grant or state exit restarts the count.
    always_ff @(posedge i_clk) begin
        if (i_rst || (r_state != StBusy) || i_gnt || w_abort) begin
            r_wait <= '0;
        end else begin
            r_wait <= r_wait + 1'b1;
        end
    end

    // Sticky abort flag.
    always_ff @(posedge i_clk) begin
        if (i_rst)        r_err <= 1'b0;
        else if (w_abort) r_err <= 1'b1;
    end
`else
    logic w_unused_timeout;

    assign w_abort          = 1'b0;
    assign o_err_timeout    = 1'b0;
    assign w_unused_timeout = ^TIMEOUT;
`endif

endmodule

// File: tb/tb_arb_requester.sv
// Scoreboard bench for arb_requester: stimulus pushes expected beats, a negedge monitor
// pops and compares every issued beat. Timeout scenario runs when REQ_TIMEOUT_EN is defined.
module tb_arb_requester;
    import arb_req_pkg::*;

    typedef struct {
        logic [15:0] addr;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic        req;
    logic        gnt;
    logic        gnt_en;
    logic        bus_valid;
    logic [15:0] bus_addr;
    logic        bus_last;
    logic        err_timeout;

    beat_t sb[$];
    int    n_checks = 0;
    int    n_errs   = 0;

    assign gnt = gnt_en & req;

    always #5 clk = ~clk;

    arb_requester #(
        .AW      (16),
        .LW      (4),
        .DEPTH   (4),
        .MIN_GAP (1),
        .TIMEOUT (8)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_cmd_valid   (cmd_valid),
        .o_cmd_ready   (cmd_ready),
        .i_cmd_addr    (cmd_addr),
        .i_cmd_len     (cmd_len),
        .o_req         (req),
        .i_gnt         (gnt),
        .o_bus_valid   (bus_valid),
        .o_bus_addr    (bus_addr),
        .o_bus_last    (bus_last),
        .o_err_timeout (err_timeout)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Monitor: every issued beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", {16'h0, bus_addr}, 32'hFFFF_FFFF);
            end else begin
                beat_t e;
                e = sb.pop_front();
                chk("beat_addr", {16'h0, bus_addr}, {16'h0, e.addr});
                chk("beat_last", {31'h0, bus_last}, {31'h0, e.last});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_burst(input logic [15:0] a, input logic [3:0] l);
        beat_t e;
        for (int i = 0; i <= int'(l); i++) begin
            e.addr = a + 16'(i);
            e.last = (i == int'(l));
            sb.push_back(e);
        end
    endtask

    // Offer one command and hold it until accepted; exp selects scoreboard update.
    task automatic push_cmd(input logic [15:0] a, input logic [3:0] l, input bit exp);
        int n;
        n         = 0;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("push_accept", 32'h0, 32'h1);
        else if (exp)   expect_burst(a, l);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || req) && n < 300) begin
            tick();
            n++;
        end
        chk("drain_empty", sb.size(), 0);
        repeat (4) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        cmd_t ct;
        int   acc, k, hi, lo_run, n;
        bit   seen_hi, seen_fall, done;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        gnt_en    = 1'b0;

        // Reset
        repeat (3) tick();
        @(negedge clk);
        chk("rst_req", {31'h0, req}, 32'h0);
        chk("rst_bus_valid", {31'h0, bus_valid}, 32'h0);
        chk("rst_bus_last", {31'h0, bus_last}, 32'h0);
        chk("rst_err", {31'h0, err_timeout}, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        tick();

        // Single burst: 0x10..0x13, four granted cycles
        gnt_en = 1'b1;
        push_cmd(16'h0010, 4'd3, 1'b1);
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (req) hi++;
        end
        chk("single_req_cycles", hi, 4);
        tick();
        drain();

        // Grant loss after beat 0x11
        push_cmd(16'h0010, 4'd3, 1'b1);
        n = 0;
        @(negedge clk);
        while (!(bus_valid && bus_addr == 16'h0011) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("gloss_saw_0x11", {31'h0, bus_valid}, 32'h1);
        gnt_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("gloss_req_held", {31'h0, req}, 32'h1);
            chk("gloss_no_beat", {31'h0, bus_valid}, 32'h0);
        end
        gnt_en = 1'b1;
        tick();
        drain();

        // Full FIFO with no grant: five commands taken, sixth refused
        gnt_en = 1'b0;
        acc    = 0;
        k      = 0;
        cmd_valid = 1'b1;
        cmd_addr  = 16'h0200;
        cmd_len   = 4'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                expect_burst(cmd_addr, cmd_len);
                acc++;
                k++;
            end
            tick();
            cmd_addr = 16'h0200 + 16'(k);
        end
        cmd_valid = 1'b0;
        chk("full_accepted", acc, 5);
        @(negedge clk);
        chk("full_ready_low", {31'h0, cmd_ready}, 32'h0);
        gnt_en = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus_valid && n < 20) begin
            chk("full_ready_wait", {31'h0, cmd_ready}, 32'h0);
            @(negedge clk);
            n++;
        end
        chk("full_ready_first_beat", {31'h0, cmd_ready}, 32'h0);
        @(negedge clk);
        chk("full_ready_after_burst", {31'h0, cmd_ready}, 32'h1);
        tick();
        drain();

        // Back-to-back bursts with wrap: req low exactly one cycle between them
        push_cmd(16'h0100, 4'd1, 1'b1);
        ct.addr = 16'hFFFF;
        ct.len  = 4'd1;
        push_cmd(ct.addr, ct.len, 1'b1);
        hi        = 0;
        lo_run    = 0;
        seen_hi   = 1'b0;
        seen_fall = 1'b0;
        done      = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (req) begin
                hi++;
                if (seen_fall) done = 1'b1;
                seen_hi = 1'b1;
            end else if (seen_hi && !done) begin
                seen_fall = 1'b1;
                lo_run++;
            end
        end
        chk("b2b_req_gap", lo_run, 1);
        chk("b2b_req_cycles", hi, 4);
        tick();
        drain();

`ifdef REQ_TIMEOUT_EN
        // Timeout: eight ungranted busy cycles, then abort; next command completes
        gnt_en = 1'b0;
        push_cmd(16'h0300, 4'd2, 1'b0);
        n = 0;
        @(negedge clk);
        while (!req && n < 10) begin
            @(negedge clk);
            n++;
        end
        hi = 0;
        while (req && hi < 40) begin
            hi++;
            @(negedge clk);
        end
        chk("to_busy_cycles", hi, 8);
        chk("to_err_set", {31'h0, err_timeout}, 32'h1);
        tick();
        gnt_en = 1'b1;
        push_cmd(16'h0400, 4'd1, 1'b1);
        drain();
        chk("to_err_sticky", {31'h0, err_timeout}, 32'h1);
`else
        chk("no_timeout_err", {31'h0, err_timeout}, 32'h0);
`endif

        // Reset mid-burst discards the burst and any queued commands
        gnt_en = 1'b0;
        push_cmd(16'h0500, 4'd3, 1'b0);
        push_cmd(16'h0600, 4'd3, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        gnt_en = 1'b1;
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req || bus_valid) hi++;
        end
        chk("midrst_silent", hi, 0);
        chk("midrst_err_clear", {31'h0, err_timeout}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
